din_debounce: RTL and testbench
===============================

// Module: din_debounce
// PURPOSE
//  Consumes the parallel word and DONE strobe of the sn74hc165 serial-input reader.
//  Per bit, requires DB_CNT identical consecutive scans before the debounced state DIN changes.
//  Reports bit changes to the system controller as a VALID strobe and a CHG mask.
//  Same MCLK domain as the reader; no CDC.
// PARAMETERS
//  WIDTH   16  number of input bits (matches reader Q width)
//  DB_CNT  3   consecutive differing scans required to flip a bit (legal 1..15)
//  CNT_W   4   per-bit counter width; must satisfy 2**CNT_W > DB_CNT
// PORTS
//  MCLK     in   1      system clock, 40 MHz
//  nRESET   in   1      async active-low reset
//  Q_IN     in   WIDTH  raw scan word from reader Q; stable while DONE_IN=1
//  DONE_IN  in   1      reader DONE; level, high for one dclk period (32 MCLK)
//  DIN      out  WIDTH  debounced input state
//  READY    out  1      high once first scan loaded
//  VALID    out  1      1-MCLK pulse: a scan was processed this cycle
//  CHG      out  WIDTH  bits that flipped (see IRQ option)
//  IRQ      out  1      change interrupt (option)
//  IRQ_ACK  in   1      1-MCLK pulse, clears latched CHG (option)
// BEHAVIOUR
//  Reset (async, nRESET=0): DIN=0, READY=0, VALID=0, CHG=0, IRQ=0, all counters 0, FSM=S_WAIT.
//  - Also applies mid-scan.
//  Edge detect: done_d <= DONE_IN each MCLK; scan = DONE_IN & ~done_d.
//  - One scan per DONE high period, however long DONE stays high.
//  FSM, 2 states:
//  - S_WAIT: on scan, DIN <= Q_IN directly, counters cleared, READY <= 1, VALID <= 1,
//    CHG unchanged (no changes reported on first load); -> S_RUN.
//  - S_RUN: on scan, per bit i:
//    - Q_IN[i]==DIN[i]: cnt[i] <= 0.
//    - differs, cnt[i] < DB_CNT-1: cnt[i] <= cnt[i]+1.
//    - differs, cnt[i] == DB_CNT-1: DIN[i] <= Q_IN[i], cnt[i] <= 0, chg_now[i]=1.
//  - VALID <= 1 for exactly one MCLK after each scan edge.
//  - No exit from S_RUN except reset.
//  Latency: DIN/VALID/CHG update on the MCLK edge sampling scan=1, i.e. 1 MCLK after
//  DONE_IN rises.
//  DB_CNT=1: a bit flips on the first differing scan.
//  Counter saturation impossible: cleared at DB_CNT-1.
//  Glitch rejection: a bit that differs on DB_CNT-1 scans then matches once restarts from 0.
// CONFIGURATION
//  Macro DIN_CHANGE_IRQ_EN:
//  - Defined:
//    - CHG is sticky: chg <= (chg & ~{WIDTH{IRQ_ACK}}) | chg_now.
//    - IRQ = |CHG, registered.
//    - ACK coincident with a new change: new bits stay set, IRQ stays 1.
//    - ACK with CHG=0 is a no-op.
//  - Undefined:
//    - CHG = chg_now, registered, valid only with VALID, 0 otherwise.
//    - IRQ tied 0; IRQ_ACK ignored (unconnected input).
// STRUCTURE
//  Include file din_defs.vh: `define DIN_S_WAIT 1'b0, `define DIN_S_RUN 1'b1,
//  default WIDTH/DB_CNT/CNT_W.
//  Sub-module din_db_bit: one bit's counter and state (ports MCLK, nRESET, scan, load,
//  raw, db, chg); instantiated WIDTH times via generate.
//  Top holds edge detect, FSM, VALID/CHG/IRQ registers.
// TESTING
//  1 Reset, one scan Q_IN=16'hA5A5 -> DIN=A5A5, READY=1, VALID 1 cycle, CHG=0, IRQ=0.
//  2 DB_CNT=3, after DIN=0000, three scans of 0001 -> DIN[0] flips on 3rd scan only,
//    CHG=0001; with macro IRQ=1 until IRQ_ACK.
//  3 Scans 0001,0001,0000,0001,0001 from DIN=0000 -> DIN stays 0000, CHG=0 throughout.
//  4 DONE_IN held high 100 MCLK -> exactly one VALID pulse.
//  5 Macro on: IRQ_ACK on same cycle as new flip of bit 15 -> CHG=8000, IRQ remains 1.
//  6 nRESET low between 2nd and 3rd qualifying scan -> all outputs 0, S_WAIT;
//    next scan loads directly.

Source files
------------

// File: rtl/din_debounce_pkg.sv
// rtl/din_debounce_pkg.sv - shared defaults and FSM state type for din_debounce
package din_debounce_pkg;

    // Default geometry: matches the sn74hc165 reader Q width
    localparam int DIN_WIDTH  = 16;
    // Consecutive differing scans needed to flip a debounced bit (1..15)
    localparam int DIN_DB_CNT = 3;
    // Per-bit counter width; 2**DIN_CNT_W must exceed DIN_DB_CNT
    localparam int DIN_CNT_W  = 4;

    // Controller states: waiting for the first scan, then debouncing forever
    typedef enum logic {
        S_WAIT = 1'b0,
        S_RUN  = 1'b1
    } din_state_e;

endpackage

// File: rtl/din_db_bit.sv
// rtl/din_db_bit.sv - one bit's debounce counter and debounced state
module din_db_bit #(
    parameter int DB_CNT = 3,
    parameter int CNT_W  = 4
) (
    input  logic MCLK,
    input  logic nRESET,
    input  logic scan,
    input  logic load,
    input  logic raw,
    output logic db,
    output logic chg
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;

    // Next state: load copies raw, a debouncing scan counts differing samples
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        chg   = 1'b0;
        if (load) begin
            db_d  = raw;
            cnt_d = '0;
        end else if (scan) begin
            if (raw == db_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                db_d  = raw;
                cnt_d = '0;
                chg   = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter and debounced-state registers
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign db = db_q;

endmodule

// File: rtl/din_debounce.sv
// rtl/din_debounce.sv - debounces reader scans, reports changes; macro DIN_CHANGE_IRQ_EN selects sticky CHG + IRQ
module din_debounce
    import din_debounce_pkg::*;
#(
    parameter int WIDTH  = DIN_WIDTH,
    parameter int DB_CNT = DIN_DB_CNT,
    parameter int CNT_W  = DIN_CNT_W
) (
    input  logic             MCLK,
    input  logic             nRESET,
    input  logic [WIDTH-1:0] Q_IN,
    input  logic             DONE_IN,
    output logic [WIDTH-1:0] DIN,
    output logic             READY,
    output logic             VALID,
    output logic [WIDTH-1:0] CHG,
    output logic             IRQ,
    input  logic             IRQ_ACK
);

    din_state_e       state_q, state_d;
    logic             done_q;
    logic             scan;
    logic             load;
    logic             run_scan;
    logic             ready_q;
    logic             valid_q;
    logic [WIDTH-1:0] chg_now;
    logic [WIDTH-1:0] chg_q;

    // One scan per DONE high period, taken on its rising edge
    assign scan = DONE_IN & ~done_q;

    // Edge-detect delay, FSM state, READY and VALID registers
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            done_q  <= 1'b0;
            state_q <= S_WAIT;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            done_q  <= DONE_IN;
            state_q <= state_d;
            valid_q <= scan;
            if (load) begin
                ready_q <= 1'b1;
            end
        end
    end

    // First scan loads DIN directly; every later scan is debounced
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        run_scan = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (scan) begin
                    load    = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                run_scan = scan;
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        din_db_bit #(
            .DB_CNT (DB_CNT),
            .CNT_W  (CNT_W)
        ) u_bit (
            .MCLK   (MCLK),
            .nRESET (nRESET),
            .scan   (run_scan),
            .load   (load),
            .raw    (Q_IN[i]),
            .db     (DIN[i]),
            .chg    (chg_now[i])
        );
    end

`ifdef DIN_CHANGE_IRQ_EN
    logic [WIDTH-1:0] chg_d;
    logic             irq_q;

    // Sticky change mask: ACK clears old bits, new flips in the same cycle survive
    assign chg_d = (chg_q & ~{WIDTH{IRQ_ACK}}) | chg_now;

    // Latched change mask and interrupt derived from it
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            chg_q <= '0;
            irq_q <= 1'b0;
        end else begin
            chg_q <= chg_d;
            irq_q <= |chg_d;
        end
    end

    assign IRQ = irq_q;
`else
    logic unused_irq_ack;

    assign unused_irq_ack = IRQ_ACK;

    // Change mask qualifies VALID only, zero on all other cycles
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            chg_q <= '0;
        end else begin
            chg_q <= chg_now;
        end
    end

    assign IRQ = 1'b0;
`endif

    assign READY = ready_q;
    assign VALID = valid_q;
    assign CHG   = chg_q;

endmodule

// File: tb/tb_din_debounce.sv
// tb/tb_din_debounce.sv - randomized self-checking bench for din_debounce
module tb_din_debounce;

    localparam int W  = 16;
    localparam int DB = 3;

    logic         MCLK = 1'b0;
    logic         nRESET;
    logic [W-1:0] Q_IN;
    logic         DONE_IN;
    logic         IRQ_ACK;
    logic [W-1:0] DIN;
    logic         READY;
    logic         VALID;
    logic [W-1:0] CHG;
    logic         IRQ;

    din_debounce #(
        .WIDTH  (W),
        .DB_CNT (DB),
        .CNT_W  (4)
    ) dut (
        .MCLK    (MCLK),
        .nRESET  (nRESET),
        .Q_IN    (Q_IN),
        .DONE_IN (DONE_IN),
        .DIN     (DIN),
        .READY   (READY),
        .VALID   (VALID),
        .CHG     (CHG),
        .IRQ     (IRQ),
        .IRQ_ACK (IRQ_ACK)
    );

    always #5 MCLK = ~MCLK;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: debounced word, reported changes, differing-scan run lengths
    logic [W-1:0] m_din;
    logic [W-1:0] m_chg;
    bit           m_loaded;
    int           m_run [W];

    // Observations from the last scan
    logic [W-1:0] obs_din;
    logic [W-1:0] obs_chg;
    logic [W-1:0] obs_chg_after;
    logic         obs_ready;
    logic         obs_irq;
    int           obs_valid;

    function automatic void model_reset();
        m_din    = '0;
        m_chg    = '0;
        m_loaded = 1'b0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
    endfunction

    function automatic void model_scan(input logic [W-1:0] q, input logic ack);
        logic [W-1:0] now;
        now = '0;
        if (!m_loaded) begin
            m_din    = q;
            m_loaded = 1'b1;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            for (int i = 0; i < W; i++) begin
                if (q[i] != m_din[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] >= DB) begin
                        m_din[i] = q[i];
                        now[i]   = 1'b1;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
`ifdef DIN_CHANGE_IRQ_EN
        m_chg = (m_chg & ~{W{ack}}) | now;
`else
        m_chg = now;
`endif
    endfunction

    function automatic logic [W-1:0] exp_chg_idle();
`ifdef DIN_CHANGE_IRQ_EN
        return m_chg;
`else
        return '0;
`endif
    endfunction

    task automatic apply_reset();
        @(negedge MCLK);
        nRESET  = 1'b0;
        DONE_IN = 1'b0;
        Q_IN    = '0;
        IRQ_ACK = 1'b0;
        repeat (3) @(negedge MCLK);
        nRESET = 1'b1;
        model_reset();
        repeat (2) @(negedge MCLK);
    endtask

    // Present one scan word with DONE high for 'hold' cycles, capture outputs
    task automatic do_scan(input logic [W-1:0] q, input int hold, input logic ack);
        @(negedge MCLK);
        Q_IN      = q;
        DONE_IN   = 1'b1;
        IRQ_ACK   = ack;
        obs_valid = 0;
        for (int c = 0; c < hold; c++) begin
            @(posedge MCLK);
            #1;
            IRQ_ACK = 1'b0;
            if (VALID === 1'b1) obs_valid++;
            if (c == 0) begin
                obs_din   = DIN;
                obs_chg   = CHG;
                obs_ready = READY;
                obs_irq   = IRQ;
            end
        end
        @(negedge MCLK);
        DONE_IN = 1'b0;
        Q_IN    = $urandom;
        @(posedge MCLK);
        #1;
        if (VALID === 1'b1) obs_valid++;
        obs_chg_after = CHG;
        model_scan(q, ack);
    endtask

    task automatic test_reset();
        @(negedge MCLK);
        nRESET  = 1'b0;
        DONE_IN = 1'b0;
        Q_IN    = '0;
        IRQ_ACK = 1'b0;
        #1;
        tests_run++;
        if ({DIN, READY, VALID, CHG, IRQ} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: DIN=%h READY=%b VALID=%b CHG=%h IRQ=%b, required all 0",
                     DIN, READY, VALID, CHG, IRQ);
        end
        repeat (2) @(negedge MCLK);
        nRESET = 1'b1;
        model_reset();
        repeat (2) @(negedge MCLK);
        tests_run++;
        if ({READY, VALID} !== 2'b00) begin
            tests_failed++;
            $display("FAIL idle_after_reset: READY=%b VALID=%b, required 0 0", READY, VALID);
        end
    endtask

    task automatic test_first_load();
        apply_reset();
        do_scan(16'hA5A5, 1, 1'b0);
        tests_run++;
        if (obs_din !== 16'hA5A5) begin
            tests_failed++;
            $display("FAIL first_load_din: got %h, required a5a5", obs_din);
        end
        tests_run++;
        if (obs_ready !== 1'b1 || READY !== 1'b1) begin
            tests_failed++;
            $display("FAIL first_load_ready: got %b/%b, required 1", obs_ready, READY);
        end
        tests_run++;
        if (obs_valid != 1) begin
            tests_failed++;
            $display("FAIL first_load_valid: %0d pulses, required 1", obs_valid);
        end
        tests_run++;
        if (obs_chg !== '0 || obs_irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_load_chg: CHG=%h IRQ=%b, required 0000 0", obs_chg, obs_irq);
        end
    endtask

    task automatic test_debounce();
        apply_reset();
        do_scan(16'h0000, 1, 1'b0);
        for (int s = 1; s <= 3; s++) begin
            do_scan(16'h0001, 1, 1'b0);
            tests_run++;
            if (obs_din !== ((s == 3) ? 16'h0001 : 16'h0000)) begin
                tests_failed++;
                $display("FAIL debounce_din scan%0d: got %h, required %h", s, obs_din,
                         (s == 3) ? 16'h0001 : 16'h0000);
            end
            tests_run++;
            if (obs_chg !== ((s == 3) ? 16'h0001 : 16'h0000)) begin
                tests_failed++;
                $display("FAIL debounce_chg scan%0d: got %h, required %h", s, obs_chg,
                         (s == 3) ? 16'h0001 : 16'h0000);
            end
        end
`ifdef DIN_CHANGE_IRQ_EN
        tests_run++;
        if (IRQ !== 1'b1 || CHG !== 16'h0001) begin
            tests_failed++;
            $display("FAIL irq_pending: IRQ=%b CHG=%h, required 1 0001", IRQ, CHG);
        end
        @(negedge MCLK);
        IRQ_ACK = 1'b1;
        @(negedge MCLK);
        IRQ_ACK = 1'b0;
        m_chg   = '0;
        #1;
        tests_run++;
        if (IRQ !== 1'b0 || CHG !== '0) begin
            tests_failed++;
            $display("FAIL irq_ack_clear: IRQ=%b CHG=%h, required 0 0000", IRQ, CHG);
        end
`else
        tests_run++;
        if (obs_chg_after !== '0) begin
            tests_failed++;
            $display("FAIL chg_after_valid: got %h, required 0000", obs_chg_after);
        end
`endif
    endtask

    task automatic test_glitch();
        logic [W-1:0] seq [5];
        seq = '{16'h0001, 16'h0001, 16'h0000, 16'h0001, 16'h0001};
        apply_reset();
        do_scan(16'h0000, 1, 1'b0);
        for (int s = 0; s < 5; s++) begin
            do_scan(seq[s], 1, 1'b0);
            tests_run++;
            if (obs_din !== 16'h0000 || obs_chg !== 16'h0000) begin
                tests_failed++;
                $display("FAIL glitch scan%0d: DIN=%h CHG=%h, required 0000 0000", s, obs_din, obs_chg);
            end
        end
    endtask

    task automatic test_long_done();
        apply_reset();
        do_scan(16'h1234, 100, 1'b0);
        tests_run++;
        if (obs_valid != 1) begin
            tests_failed++;
            $display("FAIL long_done_valid: %0d pulses, required 1", obs_valid);
        end
        do_scan(16'h1234, 100, 1'b0);
        tests_run++;
        if (obs_valid != 1) begin
            tests_failed++;
            $display("FAIL long_done_valid2: %0d pulses, required 1", obs_valid);
        end
    endtask

`ifdef DIN_CHANGE_IRQ_EN
    task automatic test_ack_collision();
        apply_reset();
        do_scan(16'h0000, 1, 1'b0);
        repeat (DB) do_scan(16'h0001, 1, 1'b0);
        repeat (DB - 1) do_scan(16'h8001, 1, 1'b0);
        do_scan(16'h8001, 1, 1'b1);
        tests_run++;
        if (obs_chg !== 16'h8000 || obs_irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL ack_collision: CHG=%h IRQ=%b, required 8000 1", obs_chg, obs_irq);
        end
    endtask
`endif

    task automatic test_mid_reset();
        apply_reset();
        do_scan(16'h0000, 1, 1'b0);
        do_scan(16'h0001, 1, 1'b0);
        do_scan(16'h0001, 1, 1'b0);
        @(negedge MCLK);
        nRESET = 1'b0;
        #1;
        tests_run++;
        if ({DIN, READY, VALID, CHG, IRQ} !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: DIN=%h READY=%b VALID=%b CHG=%h IRQ=%b, required all 0",
                     DIN, READY, VALID, CHG, IRQ);
        end
        @(negedge MCLK);
        nRESET = 1'b1;
        model_reset();
        do_scan(16'h0001, 1, 1'b0);
        tests_run++;
        if (obs_din !== 16'h0001 || obs_chg !== 16'h0000 || obs_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset_reload: DIN=%h CHG=%h READY=%b, required 0001 0000 1",
                     obs_din, obs_chg, obs_ready);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] q;
        logic [W-1:0] prev_q;
        logic         ack;
        apply_reset();
        prev_q = $urandom;
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 2) != 0) q = prev_q;
            else q = m_din ^ (W'($urandom) & W'($urandom) & W'($urandom));
            prev_q = q;
`ifdef DIN_CHANGE_IRQ_EN
            ack = ($urandom_range(0, 3) == 0);
`else
            ack = $urandom_range(0, 1) == 1;
`endif
            do_scan(q, $urandom_range(1, 4), ack);
            tests_run++;
            if (obs_din !== m_din || obs_chg !== m_chg || obs_valid != 1 ||
                obs_chg_after !== exp_chg_idle()) begin
                tests_failed++;
                $display("FAIL random scan%0d: DIN=%h CHG=%h VALID=%0d CHGidle=%h, required %h %h 1 %h",
                         n, obs_din, obs_chg, obs_valid, obs_chg_after, m_din, m_chg, exp_chg_idle());
            end
        end
    endtask

    initial begin
        nRESET  = 1'b0;
        DONE_IN = 1'b0;
        Q_IN    = '0;
        IRQ_ACK = 1'b0;
        model_reset();
        test_reset();
        test_first_load();
        test_debounce();
        test_glitch();
        test_long_done();
`ifdef DIN_CHANGE_IRQ_EN
        test_ack_collision();
`endif
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
